// File: rtl/ysyx_25040129_csr_ctrl.sv
// CSR access sequencer between the EXU and a single-port CSR register file.
// Runs one Zicsr / ecall / mret operation at a time: IDLE -> EXEC [-> VEC] -> RESP.
module ysyx_25040129_csr_ctrl #(
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic [CSR_AW-1:0] in_csr,
  input  logic [31:0]       in_rs1_data,
  input  logic [4:0]        in_rs1_idx,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_rd_data,
  output logic              out_redirect,
  output logic [31:0]       out_redirect_pc,
  output logic              out_illegal,
  output logic              csr_write,
  output logic [CSR_AW-1:0] csr_read_addr,
  output logic [CSR_AW-1:0] csr_write_addr,
  output logic [31:0]       csr_data,
  input  logic [31:0]       csr_out
);

  localparam logic [CSR_AW-1:0] MEPC  = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] MTVEC = CSR_AW'(12'h305);

  localparam logic [1:0] OP_ZICSR = 2'b00;
  localparam logic [1:0] OP_ECALL = 2'b01;
  localparam logic [1:0] OP_MRET  = 2'b10;

  typedef enum logic [1:0] {IDLE, EXEC, VEC, RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [2:0]          f3_q;
  logic [CSR_AW-1:0]   csr_q;
  logic [31:0]         rs1_q;
  logic [4:0]          idx_q;
  logic [31:0]         pc_q;

  logic                zicsr_ok;
  logic                wr_needed;
  logic [31:0]         src;
  logic [31:0]         new_val;

  // funct3[1:0]==00 covers both illegal encodings 000 and 100.
  assign zicsr_ok  = (op_q == OP_ZICSR) && (f3_q[1:0] != 2'b00);
  assign wr_needed = (f3_q[1:0] == 2'b01) || (idx_q != 5'd0);
  assign src       = f3_q[2] ? {27'd0, idx_q} : rs1_q;

  always_comb begin
    new_val = csr_out;
    case (f3_q[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = csr_out | src;
      2'b11:   new_val = csr_out & ~src;
      default: new_val = csr_out;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == RESP);

  always_comb begin
    state_d        = state_q;
    csr_write      = 1'b0;
    csr_read_addr  = '0;
    csr_write_addr = '0;
    csr_data       = '0;
    case (state_q)
      IDLE: if (in_valid) state_d = EXEC;
      EXEC: begin
        state_d = RESP;
        if (zicsr_ok) begin
          csr_read_addr = csr_q;
          if (wr_needed) begin
            csr_write      = !rst;
            csr_write_addr = csr_q;
            csr_data       = new_val;
          end
        end else if (op_q == OP_ECALL) begin
          csr_write      = !rst;
          csr_write_addr = MEPC;
          csr_data       = pc_q;
          state_d        = VEC;
        end else if (op_q == OP_MRET) begin
          csr_read_addr = MEPC;
        end
      end
      VEC: begin
        csr_read_addr = MTVEC;
        state_d       = RESP;
      end
      RESP: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      op_q            <= '0;
      f3_q            <= '0;
      csr_q           <= '0;
      rs1_q           <= '0;
      idx_q           <= '0;
      pc_q            <= '0;
      out_rd_data     <= '0;
      out_redirect    <= 1'b0;
      out_redirect_pc <= '0;
      out_illegal     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          op_q  <= in_op;
          f3_q  <= in_funct3;
          csr_q <= in_csr;
          rs1_q <= in_rs1_data;
          idx_q <= in_rs1_idx;
          pc_q  <= in_pc;
        end
        EXEC: begin
          // Every response field is rewritten here so nothing leaks from the previous op.
          out_rd_data     <= zicsr_ok ? csr_out : 32'd0;
          out_redirect    <= (op_q == OP_MRET);
          out_redirect_pc <= (op_q == OP_MRET) ? csr_out : 32'd0;
          out_illegal     <= !zicsr_ok && (op_q != OP_ECALL) && (op_q != OP_MRET);
        end
        VEC: begin
          out_redirect    <= 1'b1;
          out_redirect_pc <= csr_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_csr_ctrl.sv
// Directed bench for the CSR sequencer with a behavioural single-port CSR file.
module tb_ysyx_25040129_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [2:0]  in_funct3;
  logic [11:0] in_csr;
  logic [31:0] in_rs1_data;
  logic [4:0]  in_rs1_idx;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rd_data;
  logic        out_redirect;
  logic [31:0] out_redirect_pc;
  logic        out_illegal;
  logic        csr_write;
  logic [11:0] csr_read_addr;
  logic [11:0] csr_write_addr;
  logic [31:0] csr_data;
  logic [31:0] csr_out;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  logic [31:0] exp_q[$];

  ysyx_25040129_csr_ctrl #(.CSR_AW(12)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_funct3(in_funct3),
    .in_csr(in_csr), .in_rs1_data(in_rs1_data), .in_rs1_idx(in_rs1_idx), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_data(out_rd_data),
    .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc), .out_illegal(out_illegal),
    .csr_write(csr_write), .csr_read_addr(csr_read_addr), .csr_write_addr(csr_write_addr),
    .csr_data(csr_data), .csr_out(csr_out)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // CSR file model: combinational read, write at the clock edge
  logic [31:0] csr_mem [0:4095];
  assign csr_out = csr_mem[csr_read_addr];
  always @(posedge clk) begin
    if (csr_write) begin
      csr_mem[csr_write_addr] <= csr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Driver tasks
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [11:0] csr,
                       input logic [31:0] rs1, input logic [4:0] idx, input logic [31:0] pc);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_in_ready: got %b want 1", in_ready);
    end
    in_op = op; in_funct3 = f3; in_csr = csr;
    in_rs1_data = rs1; in_rs1_idx = idx; in_pc = pc;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Returns the number of clock edges after the accept edge until out_valid is seen.
  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (out_valid !== 1'b1 && lat < 16);
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_funct3 = '0; in_csr = '0; in_rs1_data = '0; in_rs1_idx = '0; in_pc = '0;
    for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'd0;
    csr_mem[12'h300] <= 32'h0000_1800;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    checks++;
    if ({out_valid, out_redirect, out_illegal, csr_write} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: valid/redir/ill/wr=%b%b%b%b want 0000",
               out_valid, out_redirect, out_illegal, csr_write);
    end
    checks++;
    if (out_rd_data !== 32'd0 || out_redirect_pc !== 32'd0 || csr_data !== 32'd0 ||
        csr_read_addr !== 12'd0 || csr_write_addr !== 12'd0) begin
      errors++;
      $display("FAIL reset_data: rd=%h rpc=%h data=%h ra=%h wa=%h want all 0",
               out_rd_data, out_redirect_pc, csr_data, csr_read_addr, csr_write_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_csrrw();
    int lat;
    int w0;
    w0 = wr_cnt;
    issue(2'b00, 3'b001, 12'h305, 32'h8000_1000, 5'd5, 32'd0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL csrrw_exec_valid: got %b want 0", out_valid);
    end
    wait_resp(lat);
    checks++;
    if (lat != 1) begin
      errors++; $display("FAIL csrrw_latency: got %0d edges want 1", lat);
    end
    checks++;
    if (out_rd_data !== 32'h0 || out_redirect !== 1'b0 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL csrrw_resp: rd=%h redir=%b ill=%b want 0/0/0", out_rd_data, out_redirect, out_illegal);
    end
    drain();
    checks++;
    if (csr_mem[12'h305] !== 32'h8000_1000 || wr_cnt != w0 + 1) begin
      errors++;
      $display("FAIL csrrw_write: mtvec=%h writes=%0d want 80001000/%0d", csr_mem[12'h305], wr_cnt - w0, 1);
    end
    // csrrs with rs1=x0 is a pure read of mtvec
    w0 = wr_cnt;
    issue(2'b00, 3'b010, 12'h305, 32'hffff_ffff, 5'd0, 32'd0);
    wait_resp(lat);
    checks++;
    if (out_rd_data !== 32'h8000_1000) begin
      errors++; $display("FAIL csrrw_readback: got %h want 80001000", out_rd_data);
    end
    drain();
    checks++;
    if (wr_cnt != w0) begin
      errors++; $display("FAIL csrrw_readback_nowrite: writes=%0d want 0", wr_cnt - w0);
    end
  endtask

  task automatic test_csrrs();
    int lat;
    int w0;
    w0 = wr_cnt;
    issue(2'b00, 3'b010, 12'h300, 32'h0000_0008, 5'd3, 32'd0);
    wait_resp(lat);
    checks++;
    if (lat != 1 || out_rd_data !== 32'h0000_1800) begin
      errors++; $display("FAIL csrrs_resp: lat=%0d rd=%h want 1/00001800", lat, out_rd_data);
    end
    drain();
    checks++;
    if (csr_mem[12'h300] !== 32'h0000_1808 || wr_cnt != w0 + 1) begin
      errors++;
      $display("FAIL csrrs_write: mstatus=%h writes=%0d want 00001808/1", csr_mem[12'h300], wr_cnt - w0);
    end
    w0 = wr_cnt;
    issue(2'b00, 3'b010, 12'h300, 32'h0000_00f0, 5'd0, 32'd0);
    wait_resp(lat);
    checks++;
    if (out_rd_data !== 32'h0000_1808) begin
      errors++; $display("FAIL csrrs_x0_resp: rd=%h want 00001808", out_rd_data);
    end
    drain();
    checks++;
    if (csr_mem[12'h300] !== 32'h0000_1808 || wr_cnt != w0) begin
      errors++;
      $display("FAIL csrrs_x0_nowrite: mstatus=%h writes=%0d want 00001808/0", csr_mem[12'h300], wr_cnt - w0);
    end
  endtask

  task automatic test_illegal();
    int lat;
    int w0;
    w0 = wr_cnt;
    issue(2'b00, 3'b000, 12'h300, 32'h0000_00ff, 5'd3, 32'd0);
    wait_resp(lat);
    checks++;
    if (lat != 1 || out_illegal !== 1'b1 || out_rd_data !== 32'd0 || out_redirect !== 1'b0) begin
      errors++;
      $display("FAIL illegal_f3_resp: lat=%0d ill=%b rd=%h redir=%b want 1/1/0/0",
               lat, out_illegal, out_rd_data, out_redirect);
    end
    drain();
    checks++;
    if (wr_cnt != w0 || csr_mem[12'h300] !== 32'h0000_1808) begin
      errors++; $display("FAIL illegal_f3_nowrite: writes=%0d mstatus=%h want 0/00001808", wr_cnt - w0, csr_mem[12'h300]);
    end
    w0 = wr_cnt;
    issue(2'b11, 3'b001, 12'h300, 32'h0000_00ff, 5'd3, 32'd0);
    wait_resp(lat);
    checks++;
    if (out_illegal !== 1'b1 || out_rd_data !== 32'd0) begin
      errors++; $display("FAIL illegal_op_resp: ill=%b rd=%h want 1/0", out_illegal, out_rd_data);
    end
    drain();
    checks++;
    if (wr_cnt != w0) begin
      errors++; $display("FAIL illegal_op_nowrite: writes=%0d want 0", wr_cnt - w0);
    end
  endtask

  task automatic test_csrrci();
    int lat;
    issue(2'b00, 3'b111, 12'h300, 32'hdead_beef, 5'd8, 32'd0);
    wait_resp(lat);
    checks++;
    if (out_rd_data !== 32'h0000_1808 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL csrrci_resp: rd=%h ill=%b want 00001808/0", out_rd_data, out_illegal);
    end
    drain();
    checks++;
    if (csr_mem[12'h300] !== 32'h0000_1800) begin
      errors++; $display("FAIL csrrci_write: mstatus=%h want 00001800", csr_mem[12'h300]);
    end
  endtask

  task automatic test_ecall();
    int lat;
    int w0;
    w0 = wr_cnt;
    issue(2'b01, 3'b000, 12'h000, 32'd0, 5'd0, 32'h8000_0040);
    wait_resp(lat);
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL ecall_latency: got %0d edges want 2", lat);
    end
    checks++;
    if (out_redirect !== 1'b1 || out_redirect_pc !== 32'h8000_1000 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL ecall_resp: redir=%b rpc=%h ill=%b want 1/80001000/0", out_redirect, out_redirect_pc, out_illegal);
    end
    drain();
    checks++;
    if (csr_mem[12'h341] !== 32'h8000_0040 || wr_cnt != w0 + 1) begin
      errors++;
      $display("FAIL ecall_mepc: mepc=%h writes=%0d want 80000040/1", csr_mem[12'h341], wr_cnt - w0);
    end
  endtask

  task automatic test_mret();
    int lat;
    int w0;
    @(negedge clk);
    csr_mem[12'h341] <= 32'h8000_0044;
    w0 = wr_cnt;
    issue(2'b10, 3'b000, 12'h000, 32'd0, 5'd0, 32'h1234_5678);
    wait_resp(lat);
    checks++;
    if (lat != 1 || out_redirect !== 1'b1 || out_redirect_pc !== 32'h8000_0044) begin
      errors++;
      $display("FAIL mret_resp: lat=%0d redir=%b rpc=%h want 1/1/80000044", lat, out_redirect, out_redirect_pc);
    end
    drain();
    checks++;
    if (wr_cnt != w0) begin
      errors++; $display("FAIL mret_nowrite: writes=%0d want 0", wr_cnt - w0);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int w0;
    @(negedge clk);
    csr_mem[12'h340] <= 32'h0000_55aa;
    w0 = wr_cnt;
    issue(2'b00, 3'b001, 12'h340, 32'h1234_abcd, 5'd1, 32'd0);
    wait_resp(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'b01; in_pc = 32'hbad0_0000 + i;
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rd_data !== 32'h0000_55aa) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b in_ready=%b rd=%h want 1/0/000055aa",
                 i, out_valid, in_ready, out_rd_data);
      end
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (wr_cnt != w0 + 1 || csr_mem[12'h341] !== 32'h8000_0044 || csr_mem[12'h340] !== 32'h1234_abcd) begin
      errors++;
      $display("FAIL backpressure_ignore_in: writes=%0d mepc=%h mscratch=%h want 1/80000044/1234abcd",
               wr_cnt - w0, csr_mem[12'h341], csr_mem[12'h340]);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wr_cnt;
    issue(2'b00, 3'b001, 12'h340, 32'hffff_ffff, 5'd1, 32'd0);
    rst = 1'b1;
    #1;
    checks++;
    if (csr_write !== 1'b0) begin
      errors++; $display("FAIL reset_mid_write_gate: csr_write=%b want 0", csr_write);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || wr_cnt != w0 || csr_mem[12'h340] !== 32'h1234_abcd) begin
      errors++;
      $display("FAIL reset_mid_nochange: valid=%b writes=%0d mscratch=%h want 0/0/1234abcd",
               out_valid, wr_cnt - w0, csr_mem[12'h340]);
    end
  endtask

  // Scoreboard: each csrrw returns the value written by the one before it.
  task automatic test_back_to_back();
    int lat;
    logic [31:0] vals [3];
    logic [31:0] exp_v;
    vals[0] = 32'h0000_0001; vals[1] = 32'hcafe_f00d; vals[2] = 32'h7777_0000;
    exp_q.push_back(32'h1234_abcd);
    exp_q.push_back(vals[0]);
    exp_q.push_back(vals[1]);
    for (int i = 0; i < 3; i++) begin
      issue(2'b00, 3'b001, 12'h340, vals[i], 5'd2, 32'd0);
      wait_resp(lat);
      exp_v = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_rd_data !== exp_v) begin
        errors++;
        $display("FAIL back_to_back[%0d]: valid=%b rd=%h want 1/%h", i, out_valid, out_rd_data, exp_v);
      end
      drain();
    end
    checks++;
    if (csr_mem[12'h340] !== 32'h7777_0000) begin
      errors++; $display("FAIL back_to_back_final: mscratch=%h want 77770000", csr_mem[12'h340]);
    end
  endtask

  initial begin
    test_reset();
    test_csrrw();
    test_csrrs();
    test_illegal();
    test_csrrci();
    test_ecall();
    test_mret();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25040129_csr_ctrl.md
# ysyx_25040129_csr_ctrl

CSR access sequencer that sits between the EXU and the single-port CSR register file. It accepts one Zicsr or system operation at a time: csrrw/csrrs/csrrc and their immediate forms, ecall, or mret. It drives the CSR file's read and write ports to perform the read-modify-write or trap-sequencing steps. It returns the old CSR value for rd, or a PC redirect for ecall/mret.

## Interface
- CSR_AW, 12, CSR address width; equals the CSR file's address width.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_op  in  2  00 Zicsr instruction, 01 ecall, 10 mret, 11 reserved.
- in_funct3  in  3  Zicsr funct3.
- in_csr  in  CSR_AW  CSR address.
- in_rs1_data  in  32  rs1 value.
- in_rs1_idx  in  5  rs1 field; this is zimm for the immediate forms.
- in_pc  in  32  PC of the instruction.
- out_valid  out  1  response valid.
- out_ready  in  1  consumer accepts the response.
- out_rd_data  out  32  old CSR value.
- out_redirect  out  1  out_redirect_pc must be taken.
- out_redirect_pc  out  32  trap vector or return PC.
- out_illegal  out  1  unsupported op or funct3.
- csr_write  out  1  CSR file write enable.
- csr_read_addr  out  CSR_AW  CSR file read address.
- csr_write_addr  out  CSR_AW  CSR file write address.
- csr_data  out  32  CSR file write data.
- csr_out  in  32  CSR file combinational read data.

## Operation
- States: IDLE, EXEC, VEC, RESP.
- IDLE
  - in_ready=1.
  - On in_valid, latch all in_* fields, then go to EXEC.
- EXEC, Zicsr
  - csr_read_addr = latched csr.
  - Capture old = csr_out into out_rd_data.
  - src = rs1_data for funct3 001/010/011; src = zero-extended rs1_idx for 101/110/111.
  - new value: rw = src; rs = old | src; rc = old & ~src.
  - csr_write=1 with csr_write_addr = csr and csr_data = new when:
    - the op is rw/rwi (always), or
    - the op is rs/rc/rsi/rci and rs1_idx != 0.
  - Go to RESP.
- EXEC, ecall
  - csr_write=1, csr_write_addr = MEPC (0x341), csr_data = pc.
  - Go to VEC.
- VEC (ecall only)
  - csr_read_addr = MTVEC (0x305).
  - Capture redirect_pc = csr_out; redirect=1.
  - Go to RESP.
- EXEC, mret
  - csr_read_addr = MEPC; capture redirect_pc = csr_out; redirect=1.
  - No write. Go to RESP.
- Illegal: funct3 000/100, or op 11.
  - No write; rd_data=0, illegal=1, redirect=0.
  - Go to RESP.
- RESP
  - out_valid=1; outputs held stable.
  - Leave for IDLE when out_ready=1.
- csr_write is asserted only in EXEC; it is 0 in every other state.
- csr_read_addr is 0 when no read is needed. All csr_* outputs are registered-state-derived, not driven directly from in_*.

## Timing
- Reset: state=IDLE. in_ready=0 while rst=1, then 1 from the first cycle after rst deasserts.
- Reset values: out_valid=0, out_redirect=0, out_illegal=0, out_rd_data=0, out_redirect_pc=0, csr_write=0, csr_read_addr=0, csr_write_addr=0, csr_data=0.
- Accept at edge T (in_valid & in_ready).
- Zicsr/mret/illegal: EXEC in cycle T+1; out_valid from T+2.
- ecall: EXEC in T+1 (mepc written at end of T+1), VEC in T+2; out_valid from T+3.
- Read data is sampled in the same cycle its address is driven. A write issued in EXEC is visible to reads from the next cycle.
- Backpressure: RESP holds indefinitely while out_ready=0, and in_ready=0 meanwhile. The block is non-pipelined; at most one operation is in flight.
- in_* are ignored outside IDLE.
- rst mid-operation, in any state: return to IDLE next edge and drop out_valid. If rst is high in EXEC, csr_write is forced to 0 that cycle.
- Writes to CSRs the file does not implement are still issued. Reads of unimplemented CSRs return csr_out unchanged.

## Test plan
- csrrw, mtvec=0x0, rs1_data=0x80001000 → out_rd_data=0x0 at T+2; the next read of mtvec returns 0x80001000.
- csrrs, mstatus=0x1800, rs1_data=0x8 → out_rd_data=0x1800, mstatus=0x1808. Repeat with rs1_idx=0 → csr_write stays 0.
- csrrci, mstatus=0x1808, zimm=8 → out_rd_data=0x1808, mstatus=0x1800.
- ecall, pc=0x80000040, mtvec=0x80001000 → mepc=0x80000040; out_valid at T+3 with redirect=1, redirect_pc=0x80001000.
- mret, mepc=0x80000044 → redirect=1, redirect_pc=0x80000044 at T+2, no write.
- Backpressure and reset:
  - out_ready low 5 cycles → response stable, in_ready=0.
  - rst pulsed during EXEC of csrrw → no CSR change; IDLE with in_ready=1 after reset.
  - funct3=000 → out_illegal=1, rd_data=0, no write.
